// File: rtl/corefifo_gray_ptr_sync_pkg.sv
// Shared definitions for the CoreFIFO Gray pointer synchroniser: side encodings
// and the pointer-step integrity helper.
package corefifo_gray_ptr_sync_pkg;

   localparam int unsigned PTR_MODE_RD = 0;
   localparam int unsigned PTR_MODE_WR = 1;

   // True when more than one bit is set: clearing the lowest set bit leaves a residue.
   function automatic logic popcount_gt1(input logic [31:0] v);
      return (v & (v - 32'd1)) != 32'd0;
   endfunction

endpackage

// File: rtl/corefifo_gray_to_bin_core.sv
// Combinational Gray-to-binary conversion for an ADDRWIDTH+1 bit FIFO pointer.
module corefifo_gray_to_bin_core #(
   parameter int unsigned ADDRWIDTH = 3
) (
   input  logic [ADDRWIDTH:0] gray,
   output logic [ADDRWIDTH:0] bin
);

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      bin = '0;
      for (int i = 0; i <= int'(ADDRWIDTH); i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/corefifo_gray_ptr_sync.sv
// Synchronises the remote Gray pointer, converts it to binary, derives FIFO
// level and full/empty, and runs a sticky integrity monitor.
module corefifo_gray_ptr_sync
   import corefifo_gray_ptr_sync_pkg::*;
#(
   parameter int unsigned ADDRWIDTH   = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PIPE_CONV   = 0,
   parameter int unsigned PTR_MODE    = 0,
   parameter int unsigned ERRCNT_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDRWIDTH:0]  gray_in,
   input  logic [ADDRWIDTH:0]  local_bin,
   input  logic                err_clr,
   output logic [ADDRWIDTH:0]  remote_bin,
   output logic [ADDRWIDTH:0]  level,
   output logic                empty,
   output logic                full,
   output logic                err_flag,
   output logic [ERRCNT_W-1:0] err_cnt
);

   localparam int unsigned PTRW  = ADDRWIDTH + 1;
   localparam int unsigned DEPTH = 1 << ADDRWIDTH;

   (* async_reg = "true" *) logic [PTRW-1:0] sync [SYNC_STAGES];
   logic [PTRW-1:0] sync_last;
   logic [PTRW-1:0] conv_bin;
   logic [PTRW-1:0] prev;
   logic            step_err;
   logic            lvl_err;
   logic            err_any;

   for (genvar k = 0; k < int'(SYNC_STAGES); k++) begin : g_sync
      if (k == 0) begin : g_head
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sync[k] <= '0;
            else       sync[k] <= gray_in;
         end
      end else begin : g_tail
         always_ff @(posedge clk or posedge reset) begin
            if (reset) sync[k] <= '0;
            else       sync[k] <= sync[k-1];
         end
      end
   end

   assign sync_last = sync[SYNC_STAGES-1];

   corefifo_gray_to_bin_core #(
      .ADDRWIDTH (ADDRWIDTH)
   ) u_conv (
      .gray (sync_last),
      .bin  (conv_bin)
   );

   if (PIPE_CONV != 0) begin : g_pipe
      always_ff @(posedge clk or posedge reset) begin
         if (reset) remote_bin <= '0;
         else       remote_bin <= conv_bin;
      end
   end else begin : g_direct
      assign remote_bin = conv_bin;
   end

   // Modular subtraction absorbs pointer wrap; the sign depends on which side we sit on.
   always_comb begin
      if (PTR_MODE == PTR_MODE_WR) level = local_bin - remote_bin;
      else                         level = remote_bin - local_bin;
   end

   assign empty = (PTR_MODE == PTR_MODE_RD) && (level == '0);
   assign full  = (PTR_MODE == PTR_MODE_WR) && (level == PTRW'(DEPTH));

   assign step_err = popcount_gt1(32'(prev ^ sync_last));
   assign lvl_err  = level > PTRW'(DEPTH);
   assign err_any  = step_err | lvl_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev <= '0;
      else       prev <= sync_last;
   end

   // A new error outranks a same-cycle clear so no event is lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_flag <= 1'b0;
         err_cnt  <= '0;
      end else begin
         if (err_any)      err_flag <= 1'b1;
         else if (err_clr) err_flag <= 1'b0;

         if (err_clr)                       err_cnt <= err_any ? ERRCNT_W'(1) : '0;
         else if (err_any && err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
      end
   end

endmodule

// File: tb/tb_corefifo_gray_ptr_sync.sv
// Directed bench for corefifo_gray_ptr_sync: read side, write side, piped and narrow-counter variants.
module tb_corefifo_gray_ptr_sync;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] gray_in;
   logic [3:0] local_bin;
   logic       err_clr;

   logic [3:0] rd_remote, rd_level, wr_remote, wr_level, pp_remote, pp_level, st_remote, st_level;
   logic       rd_empty, rd_full, wr_empty, wr_full, pp_empty, pp_full, st_empty, st_full;
   logic       rd_flag, wr_flag, pp_flag, st_flag;
   logic [7:0] rd_cnt, wr_cnt, pp_cnt;
   logic [1:0] st_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   corefifo_gray_ptr_sync #(.ADDRWIDTH(3), .SYNC_STAGES(2), .PIPE_CONV(0), .PTR_MODE(0), .ERRCNT_W(8)) u_rd (
      .clk(clk), .reset(reset), .gray_in(gray_in), .local_bin(local_bin), .err_clr(err_clr),
      .remote_bin(rd_remote), .level(rd_level), .empty(rd_empty), .full(rd_full),
      .err_flag(rd_flag), .err_cnt(rd_cnt));

   corefifo_gray_ptr_sync #(.ADDRWIDTH(3), .SYNC_STAGES(2), .PIPE_CONV(0), .PTR_MODE(1), .ERRCNT_W(8)) u_wr (
      .clk(clk), .reset(reset), .gray_in(gray_in), .local_bin(local_bin), .err_clr(err_clr),
      .remote_bin(wr_remote), .level(wr_level), .empty(wr_empty), .full(wr_full),
      .err_flag(wr_flag), .err_cnt(wr_cnt));

   corefifo_gray_ptr_sync #(.ADDRWIDTH(3), .SYNC_STAGES(2), .PIPE_CONV(1), .PTR_MODE(0), .ERRCNT_W(8)) u_pipe (
      .clk(clk), .reset(reset), .gray_in(gray_in), .local_bin(local_bin), .err_clr(err_clr),
      .remote_bin(pp_remote), .level(pp_level), .empty(pp_empty), .full(pp_full),
      .err_flag(pp_flag), .err_cnt(pp_cnt));

   corefifo_gray_ptr_sync #(.ADDRWIDTH(3), .SYNC_STAGES(2), .PIPE_CONV(0), .PTR_MODE(0), .ERRCNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .gray_in(gray_in), .local_bin(local_bin), .err_clr(err_clr),
      .remote_bin(st_remote), .level(st_level), .empty(st_empty), .full(st_full),
      .err_flag(st_flag), .err_cnt(st_cnt));

   typedef struct {
      logic [3:0] gray;
      logic [3:0] loc;
      logic [3:0] exp_remote;
      logic [3:0] exp_rd_level;
      logic [3:0] exp_wr_level;
      logic       exp_empty;
      logic       exp_full;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      gray_in = 4'b0000;
      tick(2);
      reset = 1'b0;
      tick(3);
   endtask

   initial begin
      //             gray     local    remote   rd lvl   wr lvl   empty full
      vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 4'd0,    4'd0,    1'b1, 1'b0};
      vecs[1] = '{4'b0001, 4'b1111, 4'b0001, 4'd2,    4'd14,   1'b0, 1'b0};
      vecs[2] = '{4'b0000, 4'b1000, 4'b0000, 4'd8,    4'd8,    1'b0, 1'b1};
      vecs[3] = '{4'b1101, 4'b0001, 4'b1001, 4'd8,    4'd8,    1'b0, 1'b1};
      vecs[4] = '{4'b0111, 4'b0011, 4'b0101, 4'd2,    4'd14,   1'b0, 1'b0};
      vecs[5] = '{4'b1010, 4'b1100, 4'b1100, 4'd0,    4'd0,    1'b1, 1'b0};

      // Reset with a nonzero remote pointer present
      reset     = 1'b1;
      gray_in   = 4'b0110;
      local_bin = 4'b0000;
      err_clr   = 1'b0;
      #3;
      chk("reset_remote", 32'(rd_remote), 32'h0);
      chk("reset_flag", 32'(rd_flag), 32'h0);
      chk("reset_cnt", 32'(rd_cnt), 32'h0);
      chk("reset_empty", 32'(rd_empty), 32'h1);
      tick(2);
      chk("reset_hold_remote", 32'(rd_remote), 32'h0);
      gray_in = 4'b0000;
      reset   = 1'b0;
      tick(3);

      // Latency: direct path two edges, piped path three
      gray_in = 4'b0001;
      tick(1);
      chk("lat_rd_e1", 32'(rd_remote), 32'h0);
      tick(1);
      chk("lat_rd_e2", 32'(rd_remote), 32'h1);
      chk("lat_pipe_e2", 32'(pp_remote), 32'h0);
      tick(1);
      chk("lat_pipe_e3", 32'(pp_remote), 32'h1);

      // Level, wrap, full and empty vectors on both sides
      for (int i = 0; i < 6; i++) begin
         gray_in   = vecs[i].gray;
         local_bin = vecs[i].loc;
         tick(3);
         chk($sformatf("v%0d_remote", i), 32'(rd_remote), 32'(vecs[i].exp_remote));
         chk($sformatf("v%0d_wr_remote", i), 32'(wr_remote), 32'(vecs[i].exp_remote));
         chk($sformatf("v%0d_rd_level", i), 32'(rd_level), 32'(vecs[i].exp_rd_level));
         chk($sformatf("v%0d_wr_level", i), 32'(wr_level), 32'(vecs[i].exp_wr_level));
         chk($sformatf("v%0d_empty", i), 32'(rd_empty), 32'(vecs[i].exp_empty));
         chk($sformatf("v%0d_full", i), 32'(wr_full), 32'(vecs[i].exp_full));
         chk($sformatf("v%0d_rd_full_tied", i), 32'(rd_full), 32'h0);
         chk($sformatf("v%0d_wr_empty_tied", i), 32'(wr_empty), 32'h0);
      end

      // Gray step errors, counting, and clear interplay
      local_bin = 4'b0000;
      do_reset();
      gray_in = 4'b0011;
      tick(2);
      chk("step_flag_pre", 32'(rd_flag), 32'h0);
      tick(1);
      chk("step_flag", 32'(rd_flag), 32'h1);
      chk("step_cnt", 32'(rd_cnt), 32'h1);
      tick(1);
      chk("step_cnt_hold", 32'(rd_cnt), 32'h1);
      gray_in = 4'b0000;
      tick(3);
      chk("step2_cnt", 32'(rd_cnt), 32'h2);
      gray_in = 4'b0011;
      tick(2);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("clr_err_flag", 32'(rd_flag), 32'h1);
      chk("clr_err_cnt", 32'(rd_cnt), 32'h1);
      tick(1);
      chk("clr_err_cnt_hold", 32'(rd_cnt), 32'h1);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("clr_flag", 32'(rd_flag), 32'h0);
      chk("clr_cnt", 32'(rd_cnt), 32'h0);

      // Impossible level with a 2-bit saturating counter
      do_reset();
      gray_in = 4'b1101;
      tick(8);
      chk("sat_level", 32'(st_level), 32'h9);
      chk("sat_flag", 32'(st_flag), 32'h1);
      chk("sat_cnt", 32'(st_cnt), 32'h3);
      tick(5);
      chk("sat_cnt_hold", 32'(st_cnt), 32'h3);
      chk("nosat_cnt_wide", 32'(rd_cnt > 8'd3), 32'h1);

      // Asynchronous reset between edges
      gray_in = 4'b0111;
      tick(3);
      chk("mid_pre_remote", 32'(rd_remote), 32'h5);
      chk("mid_pre_flag", 32'(rd_flag), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_remote", 32'(rd_remote), 32'h0);
      chk("mid_flag", 32'(rd_flag), 32'h0);
      chk("mid_cnt", 32'(rd_cnt), 32'h0);
      chk("mid_empty", 32'(rd_empty), 32'h1);
      gray_in = 4'b0000;
      tick(1);
      reset = 1'b0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
